// File: rtl/proc_scoreboard.sv
`default_nettype none
// ============================================================================
// proc_scoreboard : tracks in-flight register writers in X..W and gives decode
//   per-operand bypass selects and a hazard stall. Optional macro:
//   PROC_SCOREBOARD_BYPASS_EN (undefined = no bypass, stall until write-back).
// Revision: 1.0
// ============================================================================
module proc_scoreboard #(
  parameter  int NREGS   = 32,
  parameter  int NSTAGES = 3,
  localparam int AW      = $clog2(NREGS),
  localparam int SW      = $clog2(NSTAGES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_val,
  input  logic          d_rs1_en,
  input  logic          d_rs2_en,
  input  logic [AW-1:0] d_rs1,
  input  logic [AW-1:0] d_rs2,
  input  logic          d_wen,
  input  logic [AW-1:0] d_rd,
  input  logic [SW-1:0] d_rdy_stage,
  input  logic          squash_D,
  input  logic          freeze,
  output logic          stall_D,
  output logic [SW-1:0] op1_byp_sel,
  output logic [SW-1:0] op2_byp_sel,
  output logic          wb_val,
  output logic [AW-1:0] wb_rd,
  output logic          busy
);

  logic [NSTAGES:1] r_val;
  logic [NSTAGES:1] r_wen;
  logic [AW-1:0]    r_rd  [1:NSTAGES];
  logic [SW-1:0]    r_rdy [1:NSTAGES];
  logic [SW-1:0]    w_rdy_in;
  logic [SW:0]      w_res1;
  logic [SW:0]      w_res2;
  logic             w_ins;

`ifdef PROC_SCOREBOARD_BYPASS_EN
  always_comb begin
    w_rdy_in = d_rdy_stage;
    if (d_rdy_stage == '0)
      w_rdy_in = SW'(1);
    else if (d_rdy_stage > SW'(NSTAGES))
      w_rdy_in = SW'(NSTAGES);
  end
`else
  // Ready stage is irrelevant when every match waits for write-back.
  logic w_unused_rdy;
  assign w_unused_rdy = ^d_rdy_stage;
  assign w_rdy_in     = '0;
`endif

  // Returns {stall, sel}; scanning oldest to youngest lets the youngest match win.
  function automatic logic [SW:0] resolve(input logic en, input logic [AW-1:0] rs);
    logic [SW:0] res;
    res = '0;
    for (int k = NSTAGES; k >= 1; k--) begin
      if (d_val && en && (rs != '0) && r_val[k] && r_wen[k] && (r_rd[k] == rs)) begin
`ifdef PROC_SCOREBOARD_BYPASS_EN
        res = (SW'(k) >= r_rdy[k]) ? {1'b0, SW'(k)} : {1'b1, {SW{1'b0}}};
`else
        res = {1'b1, {SW{1'b0}}};
`endif
      end
    end
    return res;
  endfunction

  always_comb begin
    w_res1 = resolve(d_rs1_en, d_rs1);
    w_res2 = resolve(d_rs2_en, d_rs2);
  end

  assign stall_D     = w_res1[SW] | w_res2[SW];
  assign op1_byp_sel = w_res1[SW-1:0];
  assign op2_byp_sel = w_res2[SW-1:0];
  assign w_ins       = d_val & ~stall_D & ~squash_D;

  // Outputs are masked during freeze so a held W entry is not written twice.
  assign wb_val = ~freeze & r_val[NSTAGES] & r_wen[NSTAGES];
  assign wb_rd  = freeze ? '0 : r_rd[NSTAGES];
  assign busy   = |r_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val <= '0;
      r_wen <= '0;
      for (int k = 1; k <= NSTAGES; k++) begin
        r_rd[k]  <= '0;
        r_rdy[k] <= '0;
      end
    end else if (!freeze) begin
      for (int k = NSTAGES; k >= 2; k--) begin
        r_val[k] <= r_val[k-1];
        r_wen[k] <= r_wen[k-1];
        r_rd[k]  <= r_rd[k-1];
        r_rdy[k] <= r_rdy[k-1];
      end
      r_val[1] <= w_ins;
      r_wen[1] <= w_ins & d_wen;
      r_rd[1]  <= w_ins ? d_rd : '0;
      r_rdy[1] <= w_ins ? w_rdy_in : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_proc_scoreboard : directed scenarios plus randomized traffic against a
//   queue-based model of the in-flight writer history.
// Revision: 1.0
// ============================================================================
module tb_proc_scoreboard;

  localparam int N = 3;
`ifdef PROC_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       d_val, d_rs1_en, d_rs2_en, d_wen, squash_D, freeze;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic [1:0] d_rdy_stage;
  logic       stall_D, wb_val, busy;
  logic [1:0] op1_byp_sel, op2_byp_sel;
  logic [4:0] wb_rd;

  int checks = 0;
  int errors = 0;

  proc_scoreboard #(.NREGS(32), .NSTAGES(N)) dut (
    .clk(clk), .rst(rst), .d_val(d_val), .d_rs1_en(d_rs1_en), .d_rs2_en(d_rs2_en),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_wen(d_wen), .d_rd(d_rd), .d_rdy_stage(d_rdy_stage),
    .squash_D(squash_D), .freeze(freeze), .stall_D(stall_D), .op1_byp_sel(op1_byp_sel),
    .op2_byp_sel(op2_byp_sel), .wb_val(wb_val), .wb_rd(wb_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // hist[i] is the instruction inserted i+1 advancing cycles ago (stage i+1).
  typedef struct {logic val; logic wen; logic [4:0] rd; int rdy;} ent_t;
  ent_t hist[$];

  function automatic void model_reset();
    ent_t z;
    z.val = 0; z.wen = 0; z.rd = 0; z.rdy = 0;
    hist.delete();
    for (int i = 0; i < N; i++) hist.push_back(z);
  endfunction

  function automatic void m_op(input logic dv, input logic en, input logic [4:0] rs,
                               output logic st, output logic [1:0] sel);
    st = 0; sel = 0;
    if (dv && en && rs != 0) begin
      for (int k = 1; k <= N; k++) begin
        if (hist[k-1].val && hist[k-1].wen && hist[k-1].rd == rs) begin
          if (BYP && k >= hist[k-1].rdy) sel = 2'(k);
          else st = 1;
          break;
        end
      end
    end
  endfunction

  task automatic tick();
    logic s1, s2;
    logic [1:0] x1, x2;
    ent_t e;
    m_op(d_val, d_rs1_en, d_rs1, s1, x1);
    m_op(d_val, d_rs2_en, d_rs2, s2, x2);
    if (rst && !freeze) begin
      e.val = d_val && !(s1 || s2) && !squash_D;
      e.wen = e.val && d_wen;
      e.rd  = e.val ? d_rd : 5'd0;
      e.rdy = (d_rdy_stage == 0) ? 1 : (int'(d_rdy_stage) > N ? N : int'(d_rdy_stage));
      hist.push_front(e);
      void'(hist.pop_back());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic dv, input logic e1, input logic [4:0] r1,
                        input logic e2, input logic [4:0] r2, input logic we,
                        input logic [4:0] rd, input logic [1:0] rdy);
    d_val = dv; d_rs1_en = e1; d_rs1 = r1; d_rs2_en = e2; d_rs2 = r2;
    d_wen = we; d_rd = rd; d_rdy_stage = rdy; squash_D = 0; freeze = 0;
  endtask

  task automatic flush();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (N) tick();
  endtask

  task automatic test_reset();
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (wb_val !== 1'b0) begin errors++; $display("FAIL reset_wb_val: got %b want 0", wb_val); end
    rst = 1;
    for (int i = 1; i <= 3; i++) begin
      set_in(1, 0, 0, 0, 0, 1, 5'(i), 2'd1);
      tick();
    end
    set_in(1, 1, 5'd3, 1, 5'd1, 0, 0, 1);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prereset_busy: got %b want 1", busy); end
    checks++; if (wb_val !== 1'b1 || wb_rd !== 5'd1) begin errors++; $display("FAIL prereset_wb: got %b/%0d want 1/1", wb_val, wb_rd); end
    rst = 0;
    #1;
    checks++; if (stall_D !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %b want 0", stall_D); end
    checks++; if (op1_byp_sel !== 2'd0 || op2_byp_sel !== 2'd0) begin errors++; $display("FAIL midreset_sel: got %0d/%0d want 0/0", op1_byp_sel, op2_byp_sel); end
    checks++; if (wb_val !== 1'b0 || wb_rd !== 5'd0) begin errors++; $display("FAIL midreset_wb: got %b/%0d want 0/0", wb_val, wb_rd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    model_reset();
    tick();
    rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL postreset_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int stalls, wb_at;
    bit pending;
    logic [1:0] s1, s2;
    flush();
    set_in(1, 0, 0, 0, 0, 1, 5'd5, 2'd1);
    tick();
    set_in(1, 1, 5'd5, 1, 5'd5, 1, 5'd6, 2'd1);
    stalls = 0; wb_at = -1; pending = 1; s1 = 2'd3; s2 = 2'd3;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      #1;
      if (wb_val === 1'b1 && wb_rd === 5'd5) wb_at = cyc;
      if (pending) begin
        if (stall_D === 1'b1) stalls++;
        else begin pending = 0; s1 = op1_byp_sel; s2 = op2_byp_sel; end
      end
      tick();
      if (!pending) set_in(0, 0, 0, 0, 0, 0, 0, 1);
    end
    checks++; if (pending) begin errors++; $display("FAIL b2b_timeout: consumer still stalled after 6 cycles"); end
    checks++; if (stalls != (BYP ? 0 : N)) begin errors++; $display("FAIL b2b_stalls: got %0d want %0d", stalls, BYP ? 0 : N); end
    checks++; if (s1 !== (BYP ? 2'd1 : 2'd0) || s2 !== (BYP ? 2'd1 : 2'd0)) begin errors++; $display("FAIL b2b_sel: got %0d/%0d want %0d/%0d", s1, s2, BYP, BYP); end
    checks++; if (wb_at != N) begin errors++; $display("FAIL b2b_wb_cycle: got %0d want %0d", wb_at, N); end
  endtask

  task automatic test_load_use();
    int stalls;
    bit pending;
    logic [1:0] s1, s2;
    flush();
    set_in(1, 0, 0, 0, 0, 1, 5'd3, 2'd2);
    tick();
    set_in(1, 1, 5'd3, 1, 5'd0, 1, 5'd4, 2'd1);
    stalls = 0; pending = 1; s1 = 2'd3; s2 = 2'd3;
    for (int cyc = 1; cyc <= 6 && pending; cyc++) begin
      #1;
      if (stall_D === 1'b1) stalls++;
      else begin pending = 0; s1 = op1_byp_sel; s2 = op2_byp_sel; end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (pending) begin errors++; $display("FAIL lu_timeout: consumer still stalled after 6 cycles"); end
    checks++; if (stalls != (BYP ? 1 : N)) begin errors++; $display("FAIL lu_stalls: got %0d want %0d", stalls, BYP ? 1 : N); end
    checks++; if (s1 !== (BYP ? 2'd2 : 2'd0) || s2 !== 2'd0) begin errors++; $display("FAIL lu_sel: got %0d/%0d want %0d/0", s1, s2, BYP ? 2 : 0); end
  endtask

  task automatic test_x0_youngest();
    flush();
    set_in(1, 0, 0, 0, 0, 1, 5'd0, 2'd2);
    tick();
    set_in(1, 1, 5'd0, 1, 5'd0, 0, 0, 1);
    #1;
    checks++; if (stall_D !== 1'b0 || op1_byp_sel !== 2'd0 || op2_byp_sel !== 2'd0) begin errors++; $display("FAIL x0: got stall=%b sel=%0d/%0d want 0 0/0", stall_D, op1_byp_sel, op2_byp_sel); end
    tick();
    flush();
    set_in(1, 0, 0, 0, 0, 1, 5'd7, 2'd3);
    tick();
    set_in(1, 0, 0, 0, 0, 1, 5'd7, 2'd1);
    tick();
    set_in(1, 1, 5'd7, 0, 0, 0, 0, 1);
    #1;
    checks++; if (stall_D !== !BYP) begin errors++; $display("FAIL youngest_stall: got %b want %b", stall_D, !BYP); end
    checks++; if (!stall_D && op1_byp_sel !== (BYP ? 2'd1 : 2'd0)) begin errors++; $display("FAIL youngest_sel: got %0d want %0d", op1_byp_sel, BYP ? 1 : 0); end
    tick();
    flush();
    set_in(1, 0, 0, 0, 0, 1, 5'd9, 2'd0);
    tick();
    set_in(1, 0, 0, 1, 5'd9, 0, 0, 1);
    #1;
    checks++; if (stall_D !== !BYP || op2_byp_sel !== (BYP ? 2'd1 : 2'd0)) begin errors++; $display("FAIL rdy0: got stall=%b sel=%0d want %b %0d", stall_D, op2_byp_sel, !BYP, BYP ? 1 : 0); end
    tick();
  endtask

  task automatic test_freeze_squash();
    flush();
    for (int i = 10; i <= 12; i++) begin
      set_in(1, 0, 0, 0, 0, 1, 5'(i), 2'd1);
      tick();
    end
    for (int f = 0; f < 4; f++) begin
      set_in(1, 1, 5'd12, 1, 5'd10, 1, 5'd13, 2'd1);
      freeze = 1;
      #1;
      checks++; if (wb_val !== 1'b0 || wb_rd !== 5'd0) begin errors++; $display("FAIL freeze_wb: cycle %0d got %b/%0d want 0/0", f, wb_val, wb_rd); end
      checks++; if (busy !== 1'b1 || stall_D !== !BYP) begin errors++; $display("FAIL freeze_state: cycle %0d got busy=%b stall=%b want 1 %b", f, busy, stall_D, !BYP); end
      checks++; if (op1_byp_sel !== (BYP ? 2'd1 : 2'd0) || op2_byp_sel !== (BYP ? 2'd3 : 2'd0)) begin errors++; $display("FAIL freeze_sel: cycle %0d got %0d/%0d want %0d/%0d", f, op1_byp_sel, op2_byp_sel, BYP ? 1 : 0, BYP ? 3 : 0); end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 10; i <= 12; i++) begin
      #1;
      checks++; if (wb_val !== 1'b1 || wb_rd !== 5'(i)) begin errors++; $display("FAIL resume_wb: got %b/%0d want 1/%0d", wb_val, wb_rd, i); end
      tick();
    end
    #1;
    checks++; if (wb_val !== 1'b0) begin errors++; $display("FAIL resume_nodup: got %b want 0", wb_val); end
    flush();
    set_in(1, 0, 0, 0, 0, 1, 5'd14, 2'd1);
    squash_D = 1;
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL squash: got busy=%b want 0", busy); end
    set_in(1, 0, 0, 0, 0, 1, 5'd3, 2'd2);
    tick();
    set_in(1, 1, 5'd3, 0, 0, 1, 5'd15, 2'd1);
    squash_D = 1;
    #1;
    checks++; if (stall_D !== 1'b1) begin errors++; $display("FAIL squash_stall: got %b want 1", stall_D); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    #1;
    checks++; if (wb_val !== 1'b1 || wb_rd !== 5'd3) begin errors++; $display("FAIL squash_stall_wb: got %b/%0d want 1/3", wb_val, wb_rd); end
    tick();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL squash_stall_advance: got busy=%b want 0", busy); end
  endtask

  task automatic test_random();
    logic s1, s2, ewb, ebusy;
    logic [1:0] x1, x2;
    logic [4:0] erd;
    flush();
    for (int i = 0; i < 400; i++) begin
      d_val = ($urandom_range(0, 3) != 0);
      d_rs1_en = 1'($urandom); d_rs1 = 5'($urandom_range(0, 7));
      d_rs2_en = 1'($urandom); d_rs2 = 5'($urandom_range(0, 7));
      d_wen = 1'($urandom); d_rd = 5'($urandom_range(0, 7));
      d_rdy_stage = 2'($urandom_range(0, 3));
      squash_D = ($urandom_range(0, 9) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      #1;
      m_op(d_val, d_rs1_en, d_rs1, s1, x1);
      m_op(d_val, d_rs2_en, d_rs2, s2, x2);
      ewb = !freeze && hist[N-1].val && hist[N-1].wen;
      erd = hist[N-1].rd;
      ebusy = 0;
      foreach (hist[j]) ebusy |= hist[j].val;
      checks++; if (stall_D !== (s1 | s2)) begin errors++; $display("FAIL rnd_stall: cycle %0d got %b want %b", i, stall_D, s1 | s2); end
      if (!(s1 | s2)) begin
        checks++; if (op1_byp_sel !== x1 || op2_byp_sel !== x2) begin errors++; $display("FAIL rnd_sel: cycle %0d got %0d/%0d want %0d/%0d", i, op1_byp_sel, op2_byp_sel, x1, x2); end
      end
      checks++; if (wb_val !== ewb) begin errors++; $display("FAIL rnd_wb_val: cycle %0d got %b want %b", i, wb_val, ewb); end
      if (freeze) begin
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rnd_wb_rd_frz: cycle %0d got %0d want 0", i, wb_rd); end
      end else if (ewb) begin
        checks++; if (wb_rd !== erd) begin errors++; $display("FAIL rnd_wb_rd: cycle %0d got %0d want %0d", i, wb_rd, erd); end
      end
      checks++; if (busy !== ebusy) begin errors++; $display("FAIL rnd_busy: cycle %0d got %b want %b", i, busy, ebusy); end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0_youngest();
    test_freeze_squash();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
